// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared definitions for the PWM duty controller.
//   state_t      : key-handling FSM encoding (IDLE, HOLD, REPEAT)
//   KEY_*        : index of each option key within option_keys
//   STEP_*       : duty step sizes for the +/-10 and +1 keys
//   apply_step() : saturating duty update for one key press
//   first_rise() : lowest-index set bit of a 4-bit key vector
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam logic [1:0] KEY_HALF = 2'd0;
  localparam logic [1:0] KEY_UP10 = 2'd1;
  localparam logic [1:0] KEY_DN10 = 2'd2;
  localparam logic [1:0] KEY_UP1  = 2'd3;

  localparam logic [7:0] STEP_BIG   = 8'd10;
  localparam logic [7:0] STEP_SMALL = 8'd1;
  localparam logic [7:0] DUTY_MAX   = 8'd255;

  // One step for the given key; results clamp at 0 and DUTY_MAX.
  function automatic logic [7:0] apply_step(input logic [1:0] key,
                                            input logic [7:0] cur,
                                            input logic [7:0] half);
    logic [7:0] res;
    case (key)
      KEY_HALF: res = half;
      KEY_UP10: res = (cur >= DUTY_MAX - STEP_BIG + 8'd1) ? DUTY_MAX : cur + STEP_BIG;
      KEY_DN10: res = (cur <= STEP_BIG) ? 8'd0 : cur - STEP_BIG;
      default:  res = (cur == DUTY_MAX) ? DUTY_MAX : cur + STEP_SMALL;
    endcase
    return res;
  endfunction

  // Lowest set bit wins when several keys rise together.
  function automatic logic [1:0] first_rise(input logic [3:0] rise);
    logic [1:0] idx;
    if (rise[0])      idx = 2'd0;
    else if (rise[1]) idx = 2'd1;
    else if (rise[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen -- millisecond prescaler.
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   clr  : synchronous clear, restarts the millisecond from zero
//   tick : one-cycle pulse every CLK_PER_MS cycles since the last clear
module ms_tick_gen #(
  parameter int CLK_PER_MS = 50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_PER_MS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl -- key-driven PWM duty controller with hold/auto-repeat.
//   CLK         : clock, rising edge
//   RST         : asynchronous active-high reset
//   option_keys : debounced key levels {+1, -10, +10, half}
//   period_end  : one-cycle pulse at the PWM counter wrap
//   duty        : duty applied to the PWM comparator (changes only at period_end)
//   duty_upd    : one-cycle pulse in the cycle duty takes a new value
//   busy        : high while a key sequence is in progress
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int         CLK_PER_MS = 50000,
  parameter int         HOLD_MS    = 500,
  parameter int         REPEAT_MS  = 100,
  parameter logic [7:0] HALF_DUTY  = 8'd127
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] option_keys,
  input  logic       period_end,
  output logic [7:0] duty,
  output logic       duty_upd,
  output logic       busy
);

  localparam int MAX_MS = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int TW     = $clog2(MAX_MS + 1);

  state_t        state, state_next;
  logic [1:0]    sel_key;
  logic [3:0]    key_prev;
  logic [3:0]    key_rise;
  logic [7:0]    pending;
  logic [TW-1:0] ms_cnt;
  logic          tick;
  logic          clr;
  logic          step_now;
  logic [1:0]    step_key;

  assign key_rise = option_keys & ~key_prev;
  assign busy     = (state != ST_IDLE);

  // Timing restarts on every state change and after every step, so each
  // interval is measured from its own starting point.
  assign clr = (state_next != state) || step_now;

  ms_tick_gen #(
    .CLK_PER_MS (CLK_PER_MS)
  ) u_ms_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    state_next = state;
    step_now   = 1'b0;
    step_key   = sel_key;
    case (state)
      ST_IDLE: begin
        if (|key_rise) begin
          state_next = ST_HOLD;
          step_now   = 1'b1;
          step_key   = first_rise(key_rise);
        end
      end
      ST_HOLD: begin
        if (!option_keys[sel_key]) begin
          state_next = ST_IDLE;
        end else if (sel_key != KEY_HALF && tick && ms_cnt == TW'(HOLD_MS - 1)) begin
          state_next = ST_REPEAT;
          step_now   = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!option_keys[sel_key]) begin
          state_next = ST_IDLE;
        end else if (tick && ms_cnt == TW'(REPEAT_MS - 1)) begin
          step_now = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      sel_key  <= KEY_HALF;
      key_prev <= '0;
      pending  <= '0;
      duty     <= '0;
      duty_upd <= 1'b0;
      ms_cnt   <= '0;
    end else begin
      state    <= state_next;
      key_prev <= option_keys;
      if (state == ST_IDLE && |key_rise) sel_key <= first_rise(key_rise);
      if (step_now) pending <= apply_step(step_key, pending, HALF_DUTY);
      // NOTE: non-blocking assignment means duty samples pending as it was
      // before any step in this same cycle; the new value waits for the
      // next period_end.
      if (period_end) duty <= pending;
      duty_upd <= period_end && (pending != duty);
      if (clr)                          ms_cnt <= '0;
      else if (tick && ms_cnt != '1)    ms_cnt <= ms_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl -- directed and random stimulus for pwm_duty_ctrl,
// compared every cycle against a behavioural model that schedules steps by
// elapsed cycles since the press.
module tb_pwm_duty_ctrl;

  localparam int CPM    = 4;
  localparam int HOLD   = 3;
  localparam int REP    = 2;
  localparam int HOLD_C = CPM * HOLD;  // cycles from press to first repeat
  localparam int REP_C  = CPM * REP;   // cycles between repeats
  localparam int HALF   = 127;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] option_keys = '0;
  logic       period_end  = 1'b0;
  logic [7:0] duty;
  logic       duty_upd;
  logic       busy;

  pwm_duty_ctrl #(
    .CLK_PER_MS (CPM),
    .HOLD_MS    (HOLD),
    .REPEAT_MS  (REP),
    .HALF_DUTY  (8'd127)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .option_keys (option_keys),
    .period_end  (period_end),
    .duty        (duty),
    .duty_upd    (duty_upd),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int upd_seen = 0;

  // Reference model state
  bit       m_active;
  int       m_sel;
  int       m_n;
  int       m_pend;
  int       m_duty;
  bit       m_upd;
  bit [3:0] m_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_step(input int key, input int p);
    int v;
    case (key)
      0:       v = HALF;
      1:       v = p + 10;
      2:       v = p - 10;
      default: v = p + 1;
    endcase
    if (v > 255) v = 255;
    if (v < 0)   v = 0;
    return v;
  endfunction

  task automatic model_zero();
    m_active = 0; m_sel = 0; m_n = 0;
    m_pend = 0; m_duty = 0; m_upd = 0; m_prev = '0;
  endtask

  // Advances the model by one clock using the inputs about to be sampled.
  task automatic model_clock(input bit [3:0] k, input bit pe);
    bit [3:0] rise;
    bit       upd_next;
    rise     = k & ~m_prev;
    upd_next = pe && (m_pend != m_duty);
    if (pe) m_duty = m_pend;
    if (!m_active) begin
      if (rise != 0) begin
        m_sel = 0;
        while (!rise[m_sel]) m_sel++;
        m_pend   = model_step(m_sel, m_pend);
        m_active = 1;
        m_n      = 0;
      end
    end else if (!k[m_sel]) begin
      m_active = 0;
    end else begin
      m_n++;
      if (m_sel != 0 && (m_n == HOLD_C || (m_n > HOLD_C && (m_n - HOLD_C) % REP_C == 0)))
        m_pend = model_step(m_sel, m_pend);
    end
    m_upd  = upd_next;
    m_prev = k;
  endtask

  task automatic step(input logic [3:0] k, input logic pe);
    option_keys = k;
    period_end  = pe;
    model_clock(k, pe);
    @(posedge CLK);
    @(negedge CLK);
    cyc_cnt++;
    if (duty_upd === 1'b1) upd_seen++;
    check("duty", 32'(duty), 32'(m_duty));
    check("duty_upd", 32'(duty_upd), 32'(m_upd));
    check("busy", 32'(busy), 32'(m_active));
  endtask

  // n cycles of key level k with period_end every 20 cycles.
  task automatic run(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) step(k, (cyc_cnt % 20) == 19);
  endtask

  task automatic press(input logic [3:0] k, input int times);
    for (int i = 0; i < times; i++) begin
      run(k, 2);
      run(4'b0000, 2);
    end
  endtask

  task automatic do_reset();
    option_keys = '0;
    period_end  = 1'b0;
    RST = 1'b1;
    #1;
    model_zero();
    check("rst_duty", 32'(duty), 32'd0);
    check("rst_upd", 32'(duty_upd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    cyc_cnt = 0;
  endtask

  initial begin
    logic [3:0] rk;
    logic       rpe;

    // Reset state and a single short +10 press
    do_reset();
    upd_seen = 0;
    run(4'b0010, 5);
    run(4'b0000, 40);
    check("pulse_duty", 32'(duty), 32'd10);
    check("pulse_upd_count", 32'(upd_seen), 32'd1);
    check("pulse_busy", 32'(busy), 32'd0);

    // Held +10: steps at press, +12 and +20 cycles, released before +28
    do_reset();
    run(4'b0010, 24);
    run(4'b0000, 40);
    check("hold_duty", 32'(duty), 32'd30);

    // Saturation at the top, then at the bottom
    do_reset();
    press(4'b0010, 25);
    run(4'b0000, 40);
    check("sat_250", 32'(duty), 32'd250);
    press(4'b0010, 1);
    run(4'b0000, 40);
    check("sat_255", 32'(duty), 32'd255);
    upd_seen = 0;
    press(4'b0010, 1);
    run(4'b0000, 40);
    check("sat_no_upd", 32'(upd_seen), 32'd0);
    check("sat_still_255", 32'(duty), 32'd255);
    do_reset();
    press(4'b1000, 5);
    run(4'b0000, 40);
    check("dn_from_5", 32'(duty), 32'd5);
    press(4'b0100, 1);
    run(4'b0000, 40);
    check("dn_to_0", 32'(duty), 32'd0);

    // Simultaneous rise picks the lower key; a second key mid-hold is ignored
    do_reset();
    run(4'b1010, 3);
    run(4'b0000, 40);
    check("prio_duty", 32'(duty), 32'd10);
    run(4'b0010, 4);
    run(4'b1010, 6);
    run(4'b0000, 40);
    check("ignore_duty", 32'(duty), 32'd20);

    // Half key held long: one load, no repeat
    do_reset();
    press(4'b0010, 20);
    run(4'b0000, 40);
    check("half_pre", 32'(duty), 32'd200);
    run(4'b0001, 100);
    run(4'b0000, 40);
    check("half_duty", 32'(duty), 32'd127);

    // Reset during REPEAT clears everything at once
    do_reset();
    run(4'b0010, 30);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_duty", 32'(duty), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_upd", 32'(duty_upd), 32'd0);
    model_zero();
    option_keys = '0;
    @(negedge CLK);
    RST = 1'b0;
    cyc_cnt = 0;
    run(4'b0000, 40);
    check("post_rst_duty", 32'(duty), 32'd0);

    // Key held across reset release counts as a fresh rising edge
    do_reset();
    RST = 1'b1;
    option_keys = 4'b1000;
    @(negedge CLK);
    RST = 1'b0;
    m_prev = '0;
    run(4'b1000, 3);
    run(4'b0000, 40);
    check("held_through_rst", 32'(duty), 32'd1);

    // Random key activity with random period_end pulses
    do_reset();
    rk = '0;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 31) == 0) rk[b] = ~rk[b];
      rpe = ($urandom_range(0, 9) == 0);
      step(rk, rpe);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
